// File: rtl/pi_lookup_arbiter.sv
// rtl/pi_lookup_arbiter.sv - round-robin arbiter sharing the pi_get_digit lookup port
module pi_lookup_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 17,
  parameter int LAT   = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*IDX_W-1:0] req_index,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [3:0]            rsp_digit,
  output logic [IDX_W-1:0]      rom_index,
  input  logic [3:0]            rom_digit,
  output logic                  idle
);

  localparam int ID_W = $clog2(NREQ);

  // Priority pointer: the requester searched first on the next grant.
  logic [ID_W-1:0]          ptr;
  logic                     hs;
  logic [ID_W-1:0]          gnt_id;
  logic [IDX_W-1:0]         gnt_index;

  // Tag pipeline: stage k holds the owner of the lookup issued k+1 cycles ago.
  logic [LAT:0]             tag_vld;
  logic [LAT:0][ID_W-1:0]   tag_id;

  logic [NREQ-1:0]          rsp_onehot;

  // Grant search: first valid requester at or above ptr, with wrap; nothing while in reset.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_id;
    req_ready = '0;
    hs        = 1'b0;
    gnt_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand    = (int'(ptr) + i) % NREQ;
      cand_id = cand[ID_W-1:0];
      if (nrst && !hs && req_valid[cand_id]) begin
        hs     = 1'b1;
        gnt_id = cand_id;
      end
    end
    if (hs) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  // Index of the granted requester, forwarded to the ROM on the handshake edge.
  always_comb begin
    gnt_index = req_index[int'(gnt_id)*IDX_W +: IDX_W];
  end

  // Pointer moves just past the winner so every requester waits at most NREQ-1 grants.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ptr <= '0;
    end else if (hs) begin
      if (gnt_id == ID_W'(NREQ-1)) begin
        ptr <= '0;
      end else begin
        ptr <= gnt_id + 1'b1;
      end
    end
  end

  // ROM index only changes on a handshake; otherwise it holds the last lookup.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rom_index <= '0;
    end else if (hs) begin
      rom_index <= gnt_index;
    end
  end

  // Ownership tags travel alongside the ROM latency so each digit finds its requester.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= hs;
      tag_id[0]  <= gnt_id;
      for (int k = 1; k <= LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  // One-hot owner of the digit currently presented by the ROM.
  always_comb begin
    rsp_onehot = '0;
    if (tag_vld[LAT]) begin
      rsp_onehot[tag_id[LAT]] = 1'b1;
    end
  end

  // Response register: single-cycle valid pulse plus the captured digit.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rsp_valid <= '0;
      rsp_digit <= '0;
    end else begin
      rsp_valid <= rsp_onehot;
      if (tag_vld[LAT]) begin
        rsp_digit <= rom_digit;
      end
    end
  end

  // Idle when nothing is in the pipeline, no response is showing and nothing is granted now.
  always_comb begin
    idle = ~(|tag_vld) & ~(|rsp_valid) & ~hs;
  end

endmodule

// File: doc/pi_lookup_arbiter.md
# pi_lookup_arbiter

Round-robin arbiter that shares the single `pi_get_digit` lookup port among `NREQ` requesters, e.g. the display refresh path, a scroll prefetcher and a debug reader. Each requester presents a digit index with a valid/ready handshake. The arbiter drives the ROM index, tracks which requester owns each in-flight lookup through the fixed ROM latency, and returns the digit to that requester with a one-cycle valid pulse. It sits between the digit consumers and `pi_get_digit` in the top level, and fully pipelines one lookup per cycle.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDX_W`, 17: digit index width, matches `pi_get_digit` index.
- `LAT`, 1: cycles from `rom_index` change to the matching `rom_digit` (≥1).

- `clk`  in  1  single clock, all logic rising-edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  request pending per requester.
- `req_index`  in  NREQ*IDX_W  per-requester index, requester k at bits [k*IDX_W +: IDX_W].
- `req_ready`  out  NREQ  one-hot or zero grant; handshake = valid & ready.
- `rsp_valid`  out  NREQ  one-hot or zero, pulse when a digit is returned.
- `rsp_digit`  out  4  returned digit, shared by all requesters, qualified by `rsp_valid`.
- `rom_index`  out  IDX_W  index driven to `pi_get_digit`.
- `rom_digit`  in  4  digit from `pi_get_digit`.
- `idle`  out  1  high when no lookup is in flight and no handshake occurs this cycle.

## Operation
- **Grant selection** is combinational from `req_valid` and the priority pointer `ptr` (log2 NREQ bits).
  - Search starts at `ptr` and proceeds upward with wrap; the first requester with valid set gets `req_ready`.
  - At most one `req_ready` bit is high. All are 0 while `nrst`=0.
- **Pointer update** on handshake with requester g: `ptr <= (g+1) mod NREQ`. With no handshake, `ptr` holds.
- **ROM index:** on handshake, `rom_index <= req_index[g]` at the next edge. With no handshake, `rom_index` holds its last value, and no spurious response is generated.
- **Tag pipeline:** a shift register of depth `LAT+1`. Each entry is {valid, requester id}.
  - Stage 0 is loaded on the same edge as `rom_index`.
  - When the entry exits the last stage, it is paired with `rom_digit`. On the next edge, `rsp_valid[id] <= 1` and `rsp_digit <= rom_digit`.
- **Requester rules:** once `req_valid` is asserted, it and `req_index` hold until handshake. The arbiter never sees a request dropped. Behaviour on violation is undefined, and the bench flags it.
- There is no response backpressure. Requesters must accept `rsp_valid` in the cycle it is high.
- **Responses return in grant order.** A requester with multiple in-flight lookups receives its digits in its own request order.
- **`idle`** = no valid tag in the pipeline, no `rsp_valid` pending issue, and no handshake this cycle.
- **Reset** (`nrst`=0 at an edge):
  - `ptr`=0, `rom_index`=0, all tags invalid, `rsp_valid`=0, `rsp_digit`=0.
  - In-flight lookups are discarded, with no response after reset release.
  - `idle`=1 after the first reset edge.

## Timing
- Handshake in cycle t:
  - `rom_index` is valid in cycle t+1.
  - `rom_digit` is valid in cycle t+1+LAT.
  - `rsp_valid`/`rsp_digit` are valid in cycle t+2+LAT. With default LAT=1, that is 3 cycles after handshake.
- **Throughput:** one handshake per cycle total, and up to LAT+2 lookups in flight.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,… with exactly one grant per cycle. Worst-case wait is NREQ-1 cycles.
- **Simultaneous events:**
  - A handshake in the same cycle as a response is legal.
  - A requester may be granted in the cycle its own previous response appears.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.

## Test plan
- **Single requester latency:** reset, then requester 1 requests index 5 with a ROM model where digit = index[3:0], LAT=1.
  - Required: `req_ready[1]` in the same cycle, `rom_index`=5 one cycle later, `rsp_valid`=4'b0010 and `rsp_digit`=5 three cycles after handshake, `rsp_valid` for exactly one cycle.
- **All four requesting continuously** from reset with indices 10,11,12,13.
  - Required: grants to requesters 0,1,2,3,0 in consecutive cycles.
  - Required: responses 10,11,12,13 arrive to the matching requester 3 cycles after each grant.
- **Pointer wrap:** after a grant to requester 1 (ptr=2), requesters 0 and 3 assert together.
  - Required: requester 3 is granted first, then requester 0 the next cycle, and ptr=1 afterwards.
- **Back-to-back:** requester 2 alone issues indices 100,101,102 on consecutive cycles.
  - Required: three consecutive `rsp_valid[2]` pulses carrying 4,5,6, with `idle` low throughout and high on the cycle after the last response.
- **Reset mid-flight:** two lookups in flight, then `nrst`=0 for one cycle.
  - Required: no `rsp_valid` ever asserts for those lookups, `rom_index`=0, `req_ready`=0 during reset, and ptr=0 afterwards.
- **LAT=3 build:** repeat the four-requester scenario.
  - Required: response latency is 5 cycles, order is preserved, and `rsp_digit` matches the ROM model on every pulse.
